// File: rtl/usb_cdc_reg_bridge_if.sv
// usb_cdc_reg_bridge_if: CDC OUT (rx) and IN (tx) byte-stream handshakes between the CDC function and the bridge
interface usb_cdc_reg_bridge_if;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       rx_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  modport master (output rx_data_i, rx_valid_i, tx_ready_i, input rx_ready_o, tx_data_o, tx_valid_o);
  modport slave  (input rx_data_i, rx_valid_i, tx_ready_i, output rx_ready_o, tx_data_o, tx_valid_o);
endinterface

// File: rtl/usb_cdc_reg_bridge.sv
// usb_cdc_reg_bridge: parses 'W' addr data / 'R' addr frames from CDC OUT, accesses a register bank, answers on CDC IN
module usb_cdc_reg_bridge #(
  parameter int         NREGS          = 8,
  parameter logic [7:0] RESET_VAL      = 8'h00,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  usb_cdc_reg_bridge_if.slave  bus,
  output logic [NREGS*8-1:0]   regs_o,
  output logic                 wr_strobe_o,
  output logic [7:0]           wr_addr_o,
  output logic                 busy_o
);
  localparam int AW = NREGS > 1 ? $clog2(NREGS) : 1;
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [8:0] NR = 9'(NREGS);
  localparam logic [7:0] OP_W = 8'h57, OP_R = 8'h52, RS_K = 8'h4B, RS_D = 8'h44, RS_E = 8'h45;
  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, RESP0, RESP1} state_t;
  state_t        r_state;
  logic          r_wr;
  logic [7:0]    r_addr, r_code, r_rdata, r_tx_data, r_wr_addr;
  logic          r_tx_valid, r_strobe;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_regs [NREGS];
  logic          w_rx_xfer, w_rx_in_range, w_addr_in_range, w_expire;
  assign bus.rx_ready_o  = !rst_i && (r_state == IDLE || r_state == GET_ADDR || r_state == GET_DATA);
  assign bus.tx_valid_o  = r_tx_valid;
  assign bus.tx_data_o   = r_tx_data;
  assign wr_strobe_o     = r_strobe;
  assign wr_addr_o       = r_wr_addr;
  assign busy_o          = r_state != IDLE;
  assign w_rx_xfer       = bus.rx_valid_i && bus.rx_ready_o;
  assign w_rx_in_range   = {1'b0, bus.rx_data_i} < NR;
  assign w_addr_in_range = {1'b0, r_addr} < NR;
  assign w_expire        = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);
  for (genvar k = 0; k < NREGS; k++) begin : g_regs
    assign regs_o[8*k +: 8] = r_regs[k];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_code     <= '0;
      r_rdata    <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_strobe   <= 1'b0;
      r_wr_addr  <= '0;
      r_cnt      <= '0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= RESET_VAL;
    end else begin
      r_strobe <= 1'b0;
      r_cnt    <= '0;
      case (r_state)
        IDLE: if (w_rx_xfer) begin
          r_wr    <= bus.rx_data_i == OP_W;
          r_code  <= RS_E;
          r_state <= (bus.rx_data_i == OP_W || bus.rx_data_i == OP_R) ? GET_ADDR : RESP0;
        end
        GET_ADDR: if (w_rx_xfer) begin
          r_addr  <= bus.rx_data_i;
          r_rdata <= r_regs[bus.rx_data_i[AW-1:0]];
          r_code  <= w_rx_in_range ? RS_D : RS_E;
          r_state <= r_wr ? GET_DATA : RESP0;
        end else if (w_expire) r_state <= IDLE;
        else r_cnt <= r_cnt + 1'b1;
        GET_DATA: if (w_rx_xfer) begin
          if (w_addr_in_range) begin
            r_regs[r_addr[AW-1:0]] <= bus.rx_data_i;
            r_strobe  <= 1'b1;
            r_wr_addr <= r_addr;
          end
          r_code  <= w_addr_in_range ? RS_K : RS_E;
          r_state <= RESP0;
        end else if (w_expire) r_state <= IDLE;
        else r_cnt <= r_cnt + 1'b1;
        // one settle cycle before the code is presented; the data byte follows back-to-back
        RESP0: if (!r_tx_valid) begin
          r_tx_valid <= 1'b1;
          r_tx_data  <= r_code;
        end else if (bus.tx_ready_i) begin
          r_tx_valid <= r_code == RS_D;
          r_tx_data  <= r_code == RS_D ? r_rdata : r_tx_data;
          r_state    <= r_code == RS_D ? RESP1 : IDLE;
        end
        RESP1: if (bus.tx_ready_i) begin
          r_tx_valid <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/usb_cdc_reg_bridge.md
Name: usb_cdc_reg_bridge

Overview:
Application-side responder on the USB CDC byte streams. Consumes host bytes from the CDC OUT stream, parses fixed-format binary register-access frames, executes them against a local register bank, and returns response bytes on the CDC IN stream. It sits between the CDC function's out_data/out_valid/out_ready and in_data/in_valid/in_ready pins and the chip's control registers.

Parameters:
NREGS, 8, number of 8-bit read/write registers (2..256); address width AW = $clog2(NREGS)
RESET_VAL, 8'h00, reset value of every register
TIMEOUT_CYCLES, 1024, idle cycles allowed mid-frame before the frame is discarded; 0 disables the timeout

Ports:
clk_i  in  1  clock, same domain as the CDC byte streams
rst_i  in  1  synchronous reset, active high
rx_data_i  in  8  byte from the CDC OUT stream
rx_valid_i  in  1  rx_data_i valid
rx_ready_o  out  1  bridge accepts rx byte
tx_data_o  out  8  response byte to the CDC IN stream
tx_valid_o  out  1  tx_data_o valid
tx_ready_i  in  1  CDC accepts tx byte
regs_o  out  NREGS*8  register bank, reg k at [8k+7:8k]
wr_strobe_o  out  1  one-cycle pulse when a register is written
wr_addr_o  out  8  address of the last write, valid with wr_strobe_o
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Handshakes: rx byte transfers on clk_i edge with rx_valid_i&rx_ready_o; tx byte on tx_valid_o&tx_ready_i. Once raised, tx_valid_o and tx_data_o hold stable until the transfer.
- Frame formats: write = 0x57 ('W'), addr, data; read = 0x52 ('R'), addr. Responses: write OK = 0x4B ('K'); read OK = 0x44 ('D') then data byte; error = 0x45 ('E').
- States: IDLE, GET_ADDR, GET_DATA, RESP0, RESP1.
- IDLE: rx_ready_o=1. Accepted byte 0x57 or 0x52 -> latch opcode, go GET_ADDR. Any other byte -> load 'E', go RESP0.
- GET_ADDR: rx_ready_o=1. On accept, latch addr. For a write, go GET_DATA. For a read with addr<NREGS, latch regs[addr] as the read value and load 'D', then go RESP0. For a read with addr>=NREGS, load 'E' and go RESP0.
- GET_DATA: rx_ready_o=1. On accept with addr<NREGS: regs[addr] updates at that edge; wr_strobe_o=1 and wr_addr_o=addr in the following cycle; load 'K'; go RESP0. On accept with addr>=NREGS: no write, no strobe, load 'E', go RESP0.
- RESP0: rx_ready_o=0, tx_valid_o=1 with the loaded code. On tx transfer: if the code is 'D', go RESP1; otherwise go IDLE.
- RESP1: tx_valid_o=1 with the latched read value. On tx transfer, go IDLE.
- tx_valid_o is registered; it is first high in the cycle after entering RESP0. No idle cycle is inserted between RESP0 and RESP1 transfers. Read data is the value captured at address accept; a write cannot occur in between.
- Latency with tx_ready_i=1: the first response byte transfers 2 cycles after the last frame byte is accepted.
- Timeout (TIMEOUT_CYCLES>0): an idle counter clears on every rx transfer and on entering GET_ADDR. In GET_ADDR/GET_DATA it increments each cycle without an rx transfer. When it reaches TIMEOUT_CYCLES: go IDLE, send no response, no write. An rx transfer in the same cycle as expiry wins (the byte is processed normally). RESP states never time out (backpressure is unbounded).
- Reset: state=IDLE, regs=RESET_VAL, tx_valid_o=0, tx_data_o=0, wr_strobe_o=0, wr_addr_o=0, busy_o=0, counter=0. rx_ready_o is forced 0 while rst_i=1. Reset mid-frame or mid-response aborts with no write and no further tx bytes.
- Arithmetic: address compared as full 8 bits against NREGS; register index uses addr[AW-1:0] only after the range check passes.

Test Plan:
- Write then read (NREGS=8): rx 57 03 A5 -> tx 4B; regs_o[31:24]=A5; wr_strobe_o pulses once with wr_addr_o=03. Then rx 52 03 -> tx 44, A5.
- Out-of-range: rx 57 08 11 -> tx 45, no strobe, regs unchanged. rx 52 FF -> tx 45 only.
- Bad opcode: rx 00 -> tx 45. Then rx 52 00 -> tx 44, 00 (reset value); the parser has resynced.
- Backpressure: tx_ready_i=0 for 20 cycles during a read response -> rx_ready_o=0 and tx_valid_o/tx_data_o=44 held stable for all 20 cycles. Release -> 44 then data, each transferred exactly once.
- Timeout (TIMEOUT_CYCLES=64): rx 57 02, then 64 idle cycles -> busy_o falls, no tx. Then rx 52 02 -> tx 44, 00. A byte arriving on cycle 64 is still accepted as the data byte.
- Reset mid-frame: rx 57 01, assert rst_i 1 cycle, then rx 7E -> tx 45. regs_o all RESET_VAL.
